pcie_cfg_init_sequencer: RTL and testbench

Parametrised root-complex bring-up sequencer that replaces the fixed init/probe controller.
- Phase 1 (local RMW): runs NUM_LCL read-modify-write operations on the local configuration space through the cfg_mgmt port, using a per-entry clear mask and set mask.
- Phase 2 (remote probe): once the link is up, issues NUM_RMT Type0 config reads to the endpoint, one outstanding at a time. It matches completions by tag, applies a timeout with bounded retry, and streams each result out.
- Sits between the PCIe hard-block cfg_mgmt interface, the TX TLP builder and the RX completion decoder.

---
 rtl/pcie_rc_pkg.sv | 31 +++
 rtl/pcie_cpl_timer.sv | 32 +++
 rtl/pcie_cfg_init_sequencer.sv | 260 ++++++++++++++++++++++++++
 tb/tb_pcie_cfg_init_sequencer.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcie_rc_pkg.sv
`default_nettype none
// ============================================================================
// pcie_rc_pkg : shared encodings and constants for the RC bring-up sequencer
// Rev 1.0
// ============================================================================
package pcie_rc_pkg;

  typedef enum logic [2:0] {
    S_LCL_RD   = 3'd0,
    S_LCL_WR   = 3'd1,
    S_LINK     = 3'd2,
    S_RMT_REQ  = 3'd3,
    S_RMT_WAIT = 3'd4,
    S_DONE     = 3'd5,
    S_ERR      = 3'd6
  } seq_state_e;

  localparam logic [2:0]  CPL_STATUS_SC       = 3'd0;
  localparam logic [3:0]  DEFAULT_FIRST_DW_BE = 4'hf;
  localparam logic [11:0] DEV_CTRL            = 12'h078;
  localparam logic [11:0] LINK_CTRL           = 12'h080;

  // Set bits are applied after the clear, so they win on overlap.
  function automatic logic [31:0] rmw_merge(input logic [31:0] rd,
                                            input logic [31:0] clr,
                                            input logic [31:0] set);
    return (rd & ~clr) | set;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pcie_cpl_timer.sv
`default_nettype none
// ============================================================================
// pcie_cpl_timer : completion timeout counter, expires at TIMEOUT_CYC-1
// Rev 1.0
// ============================================================================
module pcie_cpl_timer #(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      cnt_q <= '0;
    end else if (en_i && !expire_o) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expire_o = en_i && (cnt_q == CNT_LAST);

endmodule
`default_nettype wire

// File: rtl/pcie_cfg_init_sequencer.sv
`default_nettype none
// ============================================================================
// pcie_cfg_init_sequencer : local cfg RMW list, then remote Type0 probe reads
// Rev 1.0
// ============================================================================
module pcie_cfg_init_sequencer
  import pcie_rc_pkg::*;
#(
  parameter int         NUM_LCL     = 2,
  parameter int         NUM_RMT     = 4,
  parameter logic [7:0] TAG_BASE    = 8'h00,
  parameter int         TIMEOUT_CYC = 1024,
  parameter int         MAX_RETRY   = 2
) (
  input  logic                    user_clk,
  input  logic                    user_reset,
  input  logic                    user_lnk_up,
  input  logic                    restart,
  input  logic [NUM_LCL*10-1:0]   lcl_addr,
  input  logic [NUM_LCL*32-1:0]   lcl_clr,
  input  logic [NUM_LCL*32-1:0]   lcl_set,
  input  logic [NUM_LCL*4-1:0]    lcl_be,
  input  logic [NUM_RMT*12-1:0]   rmt_addr,
  output logic [9:0]              ctr2cfg_mgmt_addr,
  output logic [7:0]              ctr2cfg_mgmt_function_number,
  output logic                    ctr2cfg_mgmt_write,
  output logic [31:0]             ctr2cfg_mgmt_write_data,
  output logic [3:0]              ctr2cfg_mgmt_byte_enable,
  output logic                    ctr2cfg_mgmt_read,
  output logic                    ctr2cfg_mgmt_debug_access,
  input  logic [31:0]             cfg2ctr_mgmt_read_data,
  input  logic                    cfg2ctr_mgmt_write_done,
  input  logic                    cfg2ctr_mgmt_read_done,
  output logic                    ctr2tx_type0_cfg_read,
  output logic [7:0]              ctr2tx_type0_cfg_read_tag,
  output logic [11:0]             ctr2tx_type0_cfg_read_reg_addr,
  output logic [3:0]              ctr2tx_type0_cfg_read_first_dw_be,
  input  logic                    tx2ctr_type0_cfg_read_done,
  input  logic                    rx2ctr_cpl_valid,
  input  logic [7:0]              rx2ctr_cpl_tag,
  input  logic [2:0]              rx2ctr_cpl_status,
  input  logic [31:0]             rx2ctr_cpl_data,
  output logic                    res_valid,
  output logic [((NUM_RMT > 1) ? $clog2(NUM_RMT) : 1)-1:0] res_index,
  output logic [31:0]             res_data,
  output logic                    res_err,
  output logic                    busy,
  output logic                    done,
  output logic                    error
);

  localparam int LCL_W = (NUM_LCL > 1) ? $clog2(NUM_LCL) : 1;
  localparam int RMT_W = (NUM_RMT > 1) ? $clog2(NUM_RMT) : 1;
  localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [LCL_W-1:0] LCL_LAST = LCL_W'(NUM_LCL - 1);
  localparam logic [RMT_W-1:0] RMT_LAST = RMT_W'(NUM_RMT - 1);
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);

  seq_state_e       state_q;
  logic [LCL_W-1:0] lcl_idx_q;
  logic [RMT_W-1:0] rmt_idx_q;
  logic [RTY_W-1:0] retry_q;
  logic [31:0]      rd_q;

  logic [9:0]       cfg_addr_q;
  logic             cfg_wr_q;
  logic [31:0]      cfg_wdata_q;
  logic [3:0]       cfg_be_q;
  logic             cfg_rd_q;
  logic             tx_rd_q;
  logic [7:0]       tx_tag_q;
  logic [11:0]      tx_addr_q;
  logic [3:0]       tx_be_q;
  logic             res_valid_q;
  logic [RMT_W-1:0] res_index_q;
  logic [31:0]      res_data_q;
  logic             res_err_q;
  logic             busy_q;
  logic             done_q;
  logic             error_q;

  logic [9:0]       lcl_addr_cur;
  logic [31:0]      lcl_clr_cur;
  logic [31:0]      lcl_set_cur;
  logic [3:0]       lcl_be_cur;
  logic [11:0]      rmt_addr_cur;
  logic [7:0]       cur_tag;
  logic             cpl_hit;
  logic             tmr_en;
  logic             tmr_expire;

  assign lcl_addr_cur = lcl_addr[10*int'(lcl_idx_q) +: 10];
  assign lcl_clr_cur  = lcl_clr[32*int'(lcl_idx_q) +: 32];
  assign lcl_set_cur  = lcl_set[32*int'(lcl_idx_q) +: 32];
  assign lcl_be_cur   = lcl_be[4*int'(lcl_idx_q) +: 4];
  assign rmt_addr_cur = rmt_addr[12*int'(rmt_idx_q) +: 12];
  assign cur_tag      = TAG_BASE + 8'(rmt_idx_q);
  assign cpl_hit      = rx2ctr_cpl_valid && (rx2ctr_cpl_tag == cur_tag);
  assign tmr_en       = (state_q == S_RMT_WAIT);

  // Held in clear outside the wait state, so it restarts from 0 on every issue.
  pcie_cpl_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_cpl_timer (
    .clk_i    (user_clk),
    .rst_i    (user_reset),
    .clr_i    (!tmr_en),
    .en_i     (tmr_en),
    .expire_o (tmr_expire)
  );

  always_ff @(posedge user_clk) begin
    if (user_reset) begin
      state_q     <= S_LCL_RD;
      lcl_idx_q   <= '0;
      rmt_idx_q   <= '0;
      retry_q     <= '0;
      rd_q        <= '0;
      cfg_addr_q  <= '0;
      cfg_wr_q    <= 1'b0;
      cfg_wdata_q <= '0;
      cfg_be_q    <= '0;
      cfg_rd_q    <= 1'b0;
      tx_rd_q     <= 1'b0;
      tx_tag_q    <= '0;
      tx_addr_q   <= '0;
      tx_be_q     <= '0;
      res_valid_q <= 1'b0;
      res_index_q <= '0;
      res_data_q  <= '0;
      res_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      res_valid_q <= 1'b0;
      case (state_q)
        // A request is raised only while low, which guarantees an idle cycle
        // between the done edge and the next request.
        S_LCL_RD: begin
          busy_q <= 1'b1;
          if (!cfg_rd_q) begin
            cfg_rd_q   <= 1'b1;
            cfg_addr_q <= lcl_addr_cur;
            cfg_be_q   <= lcl_be_cur;
          end else if (cfg2ctr_mgmt_read_done) begin
            cfg_rd_q <= 1'b0;
            rd_q     <= cfg2ctr_mgmt_read_data;
            state_q  <= S_LCL_WR;
          end
        end
        S_LCL_WR: begin
          if (!cfg_wr_q) begin
            cfg_wr_q    <= 1'b1;
            cfg_addr_q  <= lcl_addr_cur;
            cfg_be_q    <= lcl_be_cur;
            cfg_wdata_q <= rmw_merge(rd_q, lcl_clr_cur, lcl_set_cur);
          end else if (cfg2ctr_mgmt_write_done) begin
            cfg_wr_q <= 1'b0;
            if (lcl_idx_q == LCL_LAST) begin
              rmt_idx_q <= '0;
              state_q   <= S_LINK;
            end else begin
              lcl_idx_q <= lcl_idx_q + 1'b1;
              state_q   <= S_LCL_RD;
            end
          end
        end
        S_LINK: begin
          if (user_lnk_up) begin
            state_q <= S_RMT_REQ;
          end
        end
        S_RMT_REQ: begin
          if (!user_lnk_up) begin
            tx_rd_q <= 1'b0;
            tx_be_q <= '0;
            state_q <= S_LINK;
          end else if (!tx_rd_q) begin
            tx_rd_q   <= 1'b1;
            tx_tag_q  <= cur_tag;
            tx_addr_q <= rmt_addr_cur;
            tx_be_q   <= DEFAULT_FIRST_DW_BE;
          end else if (tx2ctr_type0_cfg_read_done) begin
            tx_rd_q <= 1'b0;
            tx_be_q <= '0;
            state_q <= S_RMT_WAIT;
          end
        end
        S_RMT_WAIT: begin
          if (!user_lnk_up) begin
            state_q <= S_LINK;
          end else if (cpl_hit) begin
            res_valid_q <= 1'b1;
            res_index_q <= rmt_idx_q;
            res_err_q   <= (rx2ctr_cpl_status != CPL_STATUS_SC);
            res_data_q  <= (rx2ctr_cpl_status == CPL_STATUS_SC) ? rx2ctr_cpl_data : 32'h0;
            retry_q     <= '0;
            if (rmt_idx_q == RMT_LAST) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              rmt_idx_q <= rmt_idx_q + 1'b1;
              state_q   <= S_RMT_REQ;
            end
          end else if (tmr_expire) begin
            if (retry_q == RTY_MAX) begin
              res_valid_q <= 1'b1;
              res_index_q <= rmt_idx_q;
              res_err_q   <= 1'b1;
              res_data_q  <= 32'h0;
              busy_q      <= 1'b0;
              error_q     <= 1'b1;
              state_q     <= S_ERR;
            end else begin
              retry_q <= retry_q + 1'b1;
              state_q <= S_RMT_REQ;
            end
          end
        end
        S_DONE, S_ERR: begin
          if (restart) begin
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            busy_q    <= 1'b1;
            lcl_idx_q <= '0;
            rmt_idx_q <= '0;
            retry_q   <= '0;
            state_q   <= S_LCL_RD;
          end
        end
        default: begin
          state_q <= S_LCL_RD;
        end
      endcase
    end
  end

  assign ctr2cfg_mgmt_addr                 = cfg_addr_q;
  assign ctr2cfg_mgmt_function_number      = 8'h00;
  assign ctr2cfg_mgmt_write                = cfg_wr_q;
  assign ctr2cfg_mgmt_write_data           = cfg_wdata_q;
  assign ctr2cfg_mgmt_byte_enable          = cfg_be_q;
  assign ctr2cfg_mgmt_read                 = cfg_rd_q;
  assign ctr2cfg_mgmt_debug_access         = 1'b0;
  assign ctr2tx_type0_cfg_read             = tx_rd_q;
  assign ctr2tx_type0_cfg_read_tag         = tx_tag_q;
  assign ctr2tx_type0_cfg_read_reg_addr    = tx_addr_q;
  assign ctr2tx_type0_cfg_read_first_dw_be = tx_be_q;
  assign res_valid                         = res_valid_q;
  assign res_index                         = res_index_q;
  assign res_data                          = res_data_q;
  assign res_err                           = res_err_q;
  assign busy                              = busy_q;
  assign done                              = done_q;
  assign error                             = error_q;

endmodule
`default_nettype wire

// File: tb/tb_pcie_cfg_init_sequencer.sv
`default_nettype none
// ============================================================================
// tb_pcie_cfg_init_sequencer : BFM-driven bench with a transaction-level model
// Rev 1.0
// ============================================================================
module tb_pcie_cfg_init_sequencer;

  localparam int         NUM_LCL     = 2;
  localparam int         NUM_RMT     = 4;
  localparam logic [7:0] TAG_BASE    = 8'h00;
  localparam int         TIMEOUT_CYC = 16;
  localparam int         MAX_RETRY   = 2;

  logic user_clk = 1'b0;
  logic user_reset, user_lnk_up, restart;
  logic [NUM_LCL*10-1:0] lcl_addr;
  logic [NUM_LCL*32-1:0] lcl_clr, lcl_set;
  logic [NUM_LCL*4-1:0]  lcl_be;
  logic [NUM_RMT*12-1:0] rmt_addr;
  logic [9:0]  ctr2cfg_mgmt_addr;
  logic [7:0]  ctr2cfg_mgmt_function_number;
  logic        ctr2cfg_mgmt_write, ctr2cfg_mgmt_read, ctr2cfg_mgmt_debug_access;
  logic [31:0] ctr2cfg_mgmt_write_data;
  logic [3:0]  ctr2cfg_mgmt_byte_enable;
  logic [31:0] cfg2ctr_mgmt_read_data;
  logic        cfg2ctr_mgmt_write_done, cfg2ctr_mgmt_read_done;
  logic        ctr2tx_type0_cfg_read;
  logic [7:0]  ctr2tx_type0_cfg_read_tag;
  logic [11:0] ctr2tx_type0_cfg_read_reg_addr;
  logic [3:0]  ctr2tx_type0_cfg_read_first_dw_be;
  logic        tx2ctr_type0_cfg_read_done;
  logic        rx2ctr_cpl_valid;
  logic [7:0]  rx2ctr_cpl_tag;
  logic [2:0]  rx2ctr_cpl_status;
  logic [31:0] rx2ctr_cpl_data;
  logic        res_valid, res_err, busy, done, error;
  logic [1:0]  res_index;
  logic [31:0] res_data;

  always #5 user_clk = ~user_clk;

  pcie_cfg_init_sequencer #(
    .NUM_LCL(NUM_LCL), .NUM_RMT(NUM_RMT), .TAG_BASE(TAG_BASE),
    .TIMEOUT_CYC(TIMEOUT_CYC), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .user_clk(user_clk), .user_reset(user_reset), .user_lnk_up(user_lnk_up),
    .restart(restart), .lcl_addr(lcl_addr), .lcl_clr(lcl_clr), .lcl_set(lcl_set),
    .lcl_be(lcl_be), .rmt_addr(rmt_addr),
    .ctr2cfg_mgmt_addr(ctr2cfg_mgmt_addr),
    .ctr2cfg_mgmt_function_number(ctr2cfg_mgmt_function_number),
    .ctr2cfg_mgmt_write(ctr2cfg_mgmt_write),
    .ctr2cfg_mgmt_write_data(ctr2cfg_mgmt_write_data),
    .ctr2cfg_mgmt_byte_enable(ctr2cfg_mgmt_byte_enable),
    .ctr2cfg_mgmt_read(ctr2cfg_mgmt_read),
    .ctr2cfg_mgmt_debug_access(ctr2cfg_mgmt_debug_access),
    .cfg2ctr_mgmt_read_data(cfg2ctr_mgmt_read_data),
    .cfg2ctr_mgmt_write_done(cfg2ctr_mgmt_write_done),
    .cfg2ctr_mgmt_read_done(cfg2ctr_mgmt_read_done),
    .ctr2tx_type0_cfg_read(ctr2tx_type0_cfg_read),
    .ctr2tx_type0_cfg_read_tag(ctr2tx_type0_cfg_read_tag),
    .ctr2tx_type0_cfg_read_reg_addr(ctr2tx_type0_cfg_read_reg_addr),
    .ctr2tx_type0_cfg_read_first_dw_be(ctr2tx_type0_cfg_read_first_dw_be),
    .tx2ctr_type0_cfg_read_done(tx2ctr_type0_cfg_read_done),
    .rx2ctr_cpl_valid(rx2ctr_cpl_valid), .rx2ctr_cpl_tag(rx2ctr_cpl_tag),
    .rx2ctr_cpl_status(rx2ctr_cpl_status), .rx2ctr_cpl_data(rx2ctr_cpl_data),
    .res_valid(res_valid), .res_index(res_index), .res_data(res_data),
    .res_err(res_err), .busy(busy), .done(done), .error(error)
  );

  // Per-run configuration and endpoint behaviour
  logic [9:0]  c_addr [NUM_LCL];
  logic [31:0] c_clr  [NUM_LCL];
  logic [31:0] c_set  [NUM_LCL];
  logic [31:0] c_rd   [NUM_LCL];
  logic [3:0]  c_be   [NUM_LCL];
  logic [11:0] r_addr [NUM_RMT];
  int          withhold [NUM_RMT];
  logic [2:0]  r_stat [NUM_RMT];
  logic [31:0] r_data [NUM_RMT];
  bit          r_drop [NUM_RMT];

  always_comb begin
    lcl_addr = '0; lcl_clr = '0; lcl_set = '0; lcl_be = '0; rmt_addr = '0;
    for (int i = 0; i < NUM_LCL; i++) begin
      lcl_addr[10*i +: 10] = c_addr[i];
      lcl_clr[32*i +: 32]  = c_clr[i];
      lcl_set[32*i +: 32]  = c_set[i];
      lcl_be[4*i +: 4]     = c_be[i];
    end
    for (int j = 0; j < NUM_RMT; j++) rmt_addr[12*j +: 12] = r_addr[j];
  end

  typedef struct { int idx; logic [31:0] data; bit err; } exp_t;
  exp_t exp_q[$];

  int total = 0;
  int bad   = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int first_fail();
    for (int j = 0; j < NUM_RMT; j++) if (withhold[j] > MAX_RETRY) return j;
    return -1;
  endfunction

  task automatic rand_cfg();
    int v;
    for (int i = 0; i < NUM_LCL; i++) begin
      c_addr[i] = 10'($urandom); c_clr[i] = $urandom; c_set[i] = $urandom;
      c_rd[i]   = $urandom;      c_be[i]  = 4'($urandom_range(1, 15));
    end
    for (int j = 0; j < NUM_RMT; j++) begin
      v = $urandom_range(0, 9);
      withhold[j] = (v < 6) ? 0 : (v < 8) ? 1 : (v < 9) ? 2 : 3;
      r_addr[j] = {10'($urandom), 2'b00};
      r_stat[j] = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      r_data[j] = $urandom;
      r_drop[j] = ($urandom_range(0, 4) == 0);
    end
  endtask

  // Plays cfg_mgmt, TX and RX endpoints for one full sequence and scores results.
  task automatic run_seq(input int lnk_up_delay);
    int k = 0, rj = 0, issue_n = 0, cyc = 0, lcl_dly = 0, tx_dly = 0, last_tx = 0;
    int cpl_at = -1, stray_at = -1, down_at = -1, up_at = -1;
    int ff;
    bit gap_chk = 0, req_prev = 0, drop_used = 0, fin = 0, lnk_low_prev;
    exp_t e;
    ff = first_fail();
    if (lnk_up_delay > 0) up_at = lnk_up_delay;
    lnk_low_prev = !user_lnk_up;
    while (!fin) begin
      @(negedge user_clk);
      cyc++;
      cfg2ctr_mgmt_read_done = 0; cfg2ctr_mgmt_write_done = 0;
      tx2ctr_type0_cfg_read_done = 0; rx2ctr_cpl_valid = 0;
      cfg2ctr_mgmt_read_data = $urandom;
      rx2ctr_cpl_tag = 8'($urandom); rx2ctr_cpl_status = 3'($urandom); rx2ctr_cpl_data = $urandom;

      if (lnk_low_prev && ctr2tx_type0_cfg_read) chk_eq("req_during_link_down", 1, 0);

      if (res_valid) begin
        if (exp_q.size() == 0) chk_eq("res_unexpected", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk_eq("res_index", 32'(res_index), e.idx);
          chk_eq("res_data", res_data, e.data);
          chk_eq("res_err", 32'(res_err), 32'(e.err));
        end
      end

      if (ctr2cfg_mgmt_read) begin
        if (lcl_dly > 0) lcl_dly--;
        else begin
          if (k < NUM_LCL) begin
            chk_eq("lcl_rd_addr", 32'(ctr2cfg_mgmt_addr), 32'(c_addr[k]));
            chk_eq("lcl_rd_be", 32'(ctr2cfg_mgmt_byte_enable), 32'(c_be[k]));
            cfg2ctr_mgmt_read_data = c_rd[k];
          end else chk_eq("lcl_rd_extra", 1, 0);
          cfg2ctr_mgmt_read_done = 1;
          lcl_dly = $urandom_range(0, 3);
        end
      end
      if (ctr2cfg_mgmt_write) begin
        if (lcl_dly > 0) lcl_dly--;
        else begin
          if (k < NUM_LCL) begin
            chk_eq("lcl_wr_addr", 32'(ctr2cfg_mgmt_addr), 32'(c_addr[k]));
            chk_eq("lcl_wr_data", ctr2cfg_mgmt_write_data, (c_rd[k] & ~c_clr[k]) | c_set[k]);
          end else chk_eq("lcl_wr_extra", 1, 0);
          k++;
          cfg2ctr_mgmt_write_done = 1;
          lcl_dly = $urandom_range(0, 3);
        end
      end

      if (ctr2tx_type0_cfg_read && !req_prev && gap_chk) begin
        chk_eq("retry_gap", 32'((cyc - last_tx >= TIMEOUT_CYC + 1) && (cyc - last_tx <= TIMEOUT_CYC + 3)), 1);
        gap_chk = 0;
      end
      req_prev = ctr2tx_type0_cfg_read;
      if (ctr2tx_type0_cfg_read) begin
        if (tx_dly > 0) tx_dly--;
        else if (rj >= NUM_RMT) begin
          chk_eq("tx_extra", 1, 0);
          tx2ctr_type0_cfg_read_done = 1;
        end else begin
          chk_eq("tx_tag", 32'(ctr2tx_type0_cfg_read_tag), 32'(8'(TAG_BASE + 8'(rj))));
          chk_eq("tx_addr", 32'(ctr2tx_type0_cfg_read_reg_addr), 32'(r_addr[rj]));
          chk_eq("tx_be", 32'(ctr2tx_type0_cfg_read_first_dw_be), 32'hf);
          tx2ctr_type0_cfg_read_done = 1;
          tx_dly = $urandom_range(0, 3);
          last_tx = cyc;
          if (r_drop[rj] && !drop_used) begin
            drop_used = 1; down_at = cyc + 3; up_at = cyc + 8;
          end else begin
            issue_n++;
            if (issue_n <= withhold[rj]) begin
              stray_at = cyc + 2;
              if (issue_n == MAX_RETRY + 1) exp_q.push_back('{rj, 32'h0, 1'b1});
              else gap_chk = 1;
            end else cpl_at = cyc + $urandom_range(1, 10);
          end
        end
      end

      if (cyc == stray_at) begin
        rx2ctr_cpl_valid = 1; rx2ctr_cpl_tag = 8'h55;
        rx2ctr_cpl_status = 3'd0; rx2ctr_cpl_data = $urandom;
      end
      if (cyc == cpl_at) begin
        rx2ctr_cpl_valid = 1; rx2ctr_cpl_tag = 8'(TAG_BASE + 8'(rj));
        rx2ctr_cpl_status = r_stat[rj]; rx2ctr_cpl_data = r_data[rj];
        exp_q.push_back('{rj, (r_stat[rj] == 3'd0) ? r_data[rj] : 32'h0, r_stat[rj] != 3'd0});
        rj++; issue_n = 0; drop_used = 0;
      end

      if (cyc == down_at) user_lnk_up = 0;
      if (cyc == up_at)   user_lnk_up = 1;
      lnk_low_prev = !user_lnk_up;

      if (done || error) fin = 1;
      else if (cyc > 3000) begin chk_eq("cycle_budget", 1, 0); fin = 1; end
    end
    chk_eq("seq_done", 32'(done), 32'(ff < 0));
    chk_eq("seq_error", 32'(error), 32'(ff >= 0));
    chk_eq("busy_end", 32'(busy), 0);
    chk_eq("results_left", exp_q.size(), 0);
    chk_eq("lcl_count", k, NUM_LCL);
    chk_eq("rmt_count", rj, (ff < 0) ? NUM_RMT : ff);
    exp_q.delete();
  endtask

  task automatic do_restart();
    @(negedge user_clk); restart = 1;
    @(negedge user_clk); restart = 0;
    chk_eq("restart_busy", 32'(busy), 1);
    chk_eq("restart_done", 32'(done), 0);
    chk_eq("restart_error", 32'(error), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    user_reset = 1; user_lnk_up = 0; restart = 0;
    cfg2ctr_mgmt_read_data = 0; cfg2ctr_mgmt_write_done = 0; cfg2ctr_mgmt_read_done = 0;
    tx2ctr_type0_cfg_read_done = 0; rx2ctr_cpl_valid = 0; rx2ctr_cpl_tag = 0;
    rx2ctr_cpl_status = 0; rx2ctr_cpl_data = 0;

    c_addr[0] = 10'h001; c_clr[0] = 32'h0;  c_set[0] = 32'h07; c_be[0] = 4'h1; c_rd[0] = 32'h10;
    c_addr[1] = 10'h002; c_clr[1] = 32'hE0; c_set[1] = 32'h20; c_be[1] = 4'h1; c_rd[1] = 32'hFF;
    r_addr[0] = 12'h000; r_addr[1] = 12'h004; r_addr[2] = 12'h080; r_addr[3] = 12'h008;
    for (int j = 0; j < NUM_RMT; j++) begin
      withhold[j] = 0; r_stat[j] = 3'd0; r_data[j] = 32'hA0 + 32'(j); r_drop[j] = 0;
    end
    withhold[1] = 2;
    r_stat[2]   = 3'd1;

    repeat (3) @(negedge user_clk);
    chk_eq("rst_busy", 32'(busy), 0);
    chk_eq("rst_done", 32'(done), 0);
    chk_eq("rst_error", 32'(error), 0);
    chk_eq("rst_cfg_read", 32'(ctr2cfg_mgmt_read), 0);
    chk_eq("rst_tx_read", 32'(ctr2tx_type0_cfg_read), 0);
    chk_eq("rst_res_valid", 32'(res_valid), 0);
    user_reset = 0;
    @(negedge user_clk);
    chk_eq("busy_after_rst", 32'(busy), 1);

    // Interrupt the first write with a reset, then expect a clean restart at entry 0.
    for (int n = 0; n < 20 && !ctr2cfg_mgmt_read; n++) @(negedge user_clk);
    chk_eq("pre_rd_seen", 32'(ctr2cfg_mgmt_read), 1);
    cfg2ctr_mgmt_read_data = c_rd[0]; cfg2ctr_mgmt_read_done = 1;
    @(negedge user_clk);
    cfg2ctr_mgmt_read_done = 0;
    for (int n = 0; n < 20 && !ctr2cfg_mgmt_write; n++) @(negedge user_clk);
    chk_eq("pre_wr_seen", 32'(ctr2cfg_mgmt_write), 1);
    user_reset = 1;
    @(negedge user_clk);
    chk_eq("midwr_rst_write", 32'(ctr2cfg_mgmt_write), 0);
    chk_eq("midwr_rst_wdata", ctr2cfg_mgmt_write_data, 0);
    chk_eq("midwr_rst_busy", 32'(busy), 0);
    user_reset = 0;

    run_seq(50);

    withhold[1] = 3;
    r_drop[0]   = 1;
    do_restart();
    run_seq(0);

    for (int r = 0; r < 5; r++) begin
      rand_cfg();
      do_restart();
      run_seq(0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
